// File: rtl/affine_pipe_n.sv
// affine_pipe_n: N-stage signed affine pipeline with valid/ready backpressure, saturation and overflow tagging
module affine_pipe_n #(
  parameter int W = 16,
  parameter int N_STAGES = 2,
  parameter logic [N_STAGES*W-1:0] K_VEC = {16'sd2, 16'sd3},
  parameter logic [N_STAGES*W-1:0] B_VEC = {16'sd7, 16'sd5},
  parameter bit SAT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] X,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] Y,
  output logic                out_ovf,
  output logic                ovf_sticky,
  input  logic                ovf_clr
);
  localparam int M = 2*W+1;
  logic [N_STAGES*W-1:0] d_q, d_d;
  logic [N_STAGES-1:0] v_q, v_d, o_q, o_d, ld;
  logic sticky_q, sticky_d, rdy_q, r0, acc, ovf;
  logic [(N_STAGES+1)*W-1:0] d_in;
  logic [N_STAGES:0] v_in, o_in;
  logic signed [M-1:0] pd, pk, pb, p;
  logic [W-1:0] f;
  logic unused_top;
  assign d_in = {d_q, X};
  assign v_in = {v_q, in_valid & rdy_q};
  assign o_in = {o_q, 1'b0};
  assign unused_top = ^{d_in[(N_STAGES+1)*W-1 -: W], v_in[N_STAGES], o_in[N_STAGES]};
  // ready chain from the output backwards, plus per-stage affine step and load/hold decision
  always_comb begin
    acc = out_ready;
    ld = '0;
    d_d = d_q;
    v_d = v_q;
    o_d = o_q;
    pd = '0;
    pk = '0;
    pb = '0;
    p = '0;
    ovf = 1'b0;
    f = '0;
    for (int i = N_STAGES-1; i >= 0; i--) begin
      acc = !v_q[i] | acc;
      ld[i] = acc & v_in[i];
      pd = M'($signed(d_in[i*W +: W]));
      pk = M'($signed(K_VEC[i*W +: W]));
      pb = M'($signed(B_VEC[i*W +: W]));
      p = pd * pk + pb;
      ovf = p[M-1:W-1] != {(W+2){p[W-1]}};
      f = (SAT && ovf) ? (p[M-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : p[W-1:0];
      v_d[i] = acc ? v_in[i] : v_q[i];
      d_d[i*W +: W] = ld[i] ? f : d_q[i*W +: W];
      o_d[i] = ld[i] ? (o_in[i] | ovf) : o_q[i];
    end
    r0 = acc;
    sticky_d = (ld[N_STAGES-1] & o_d[N_STAGES-1]) | (sticky_q & !ovf_clr);
  end
  // stage registers; rdy_q holds off acceptance until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      v_q <= '0;
      o_q <= '0;
      sticky_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
      o_q <= o_d;
      sticky_q <= sticky_d;
      rdy_q <= 1'b1;
    end
  end
  assign in_ready = r0 & rdy_q;
  assign out_valid = v_q[N_STAGES-1];
  assign out_ovf = o_q[N_STAGES-1];
  assign Y = d_q[(N_STAGES-1)*W +: W];
  assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_affine_pipe_n.sv
// tb_affine_pipe_n: randomized and directed checks of affine_pipe_n against an arithmetic reference model
module tb_affine_pipe_n;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic signed [15:0] X = '0;
  logic in_ready_s, out_valid_s, out_ovf_s, ovf_sticky_s;
  logic in_ready_w, out_valid_w, out_ovf_w, ovf_sticky_w;
  logic signed [15:0] Y_s, Y_w;
  int nvec = 0, nerr = 0;
  typedef struct {logic signed [15:0] ys, yw; logic os, ow;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic obs_acc, obs_pop, obs_valid, obs_ready, obs_os, obs_ow, obs_sticky;
  logic signed [15:0] obs_ys, obs_yw;

  always #5 clk = ~clk;

  affine_pipe_n #(.W(16), .N_STAGES(2), .K_VEC({16'sd2, 16'sd3}), .B_VEC({16'sd7, 16'sd5}), .SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .X(X),
    .out_valid(out_valid_s), .out_ready(out_ready), .Y(Y_s), .out_ovf(out_ovf_s),
    .ovf_sticky(ovf_sticky_s), .ovf_clr(ovf_clr));

  affine_pipe_n #(.W(16), .N_STAGES(2), .K_VEC({16'sd2, 16'sd3}), .B_VEC({16'sd7, 16'sd5}), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .X(X),
    .out_valid(out_valid_w), .out_ready(out_ready), .Y(Y_w), .out_ovf(out_ovf_w),
    .ovf_sticky(ovf_sticky_w), .ovf_clr(ovf_clr));

  // whole-pipeline result: stage 0 uses K=3,B=5, stage 1 uses K=2,B=7
  function automatic void model(input int x, input bit sat, output int y, output bit ovf);
    int ks[2] = '{3, 2};
    int bs[2] = '{5, 7};
    longint p;
    y = x;
    ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p = longint'(y) * ks[i] + bs[i];
      if (p > 32767 || p < -32768) ovf = 1'b1;
      if (sat) y = p > 32767 ? 32767 : (p < -32768 ? -32768 : int'(p));
      else y = int'(((p + 32768) % 65536 + 65536) % 65536) - 32768;
    end
  endfunction

  task automatic tick();
    int ys, yw;
    bit os, ow;
    @(negedge clk);
    obs_ready = in_ready_s;
    obs_valid = out_valid_s;
    obs_ys = Y_s;
    obs_yw = Y_w;
    obs_os = out_ovf_s;
    obs_ow = out_ovf_w;
    obs_sticky = ovf_sticky_s;
    obs_acc = in_valid & in_ready_s;
    obs_pop = out_valid_s & out_ready;
    if (obs_acc) begin
      model(int'(X), 1'b1, ys, os);
      model(int'(X), 1'b0, yw, ow);
      exp_q.push_back('{16'(ys), 16'(yw), os, ow});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++; if (out_valid_s !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid_s); end
    nvec++; if (Y_s !== 16'sd0) begin nerr++; $display("FAIL reset_Y: got %0d want 0", Y_s); end
    nvec++; if (out_ovf_s !== 1'b0) begin nerr++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf_s); end
    nvec++; if (ovf_sticky_s !== 1'b0) begin nerr++; $display("FAIL reset_sticky: got %b want 0", ovf_sticky_s); end
    nvec++; if (out_valid_w !== 1'b0) begin nerr++; $display("FAIL reset_out_valid_w: got %b want 0", out_valid_w); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nvec++; if (in_ready_s !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready_s); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    exp_q.delete();
    out_ready = 1'b1;
    X = 16'sd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++; if (obs_acc !== 1'b1) begin nerr++; $display("FAIL single_accept: got %b want 1", obs_acc); end
    tick();
    nvec++; if (obs_valid !== 1'b0) begin nerr++; $display("FAIL single_early_valid: got %b want 0", obs_valid); end
    tick();
    nvec++; if (obs_valid !== 1'b1) begin nerr++; $display("FAIL single_latency: out_valid got %b want 1", obs_valid); end
    nvec++; if (obs_ys !== 16'sd77 || obs_yw !== 16'sd77) begin nerr++; $display("FAIL single_Y: got %0d/%0d want 77", obs_ys, obs_yw); end
    nvec++; if (obs_os !== 1'b0) begin nerr++; $display("FAIL single_ovf: got %b want 0", obs_os); end
  endtask

  task automatic test_back_to_back();
    int tbl[4] = '{23, 29, 35, 41};
    int n = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = c < 4;
      X = 16'(c + 1);
      tick();
      if (c < 4) begin
        nvec++; if (obs_acc !== 1'b1) begin nerr++; $display("FAIL b2b_accept%0d: got %b want 1", c, obs_acc); end
      end
      if (obs_pop) begin
        nvec++;
        if (n > 3) begin nerr++; $display("FAIL b2b_extra: got Y=%0d want none", obs_ys); end
        else if (obs_ys !== 16'(tbl[n]) || c != n + 2) begin
          nerr++; $display("FAIL b2b_out%0d: got Y=%0d at cycle %0d want Y=%0d at cycle %0d", n, obs_ys, c, tbl[n], n + 2);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    nvec++; if (n != 4) begin nerr++; $display("FAIL b2b_count: got %0d want 4", n); end
  endtask

  task automatic test_backpressure();
    int tbl[4] = '{23, 29, 35, 41};
    int idx = 0, n = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      X = 16'(idx + 1);
      tick();
      if (obs_acc) idx++;
      if (obs_valid) begin
        nvec++; if (obs_ys !== 16'sd23) begin nerr++; $display("FAIL bp_hold_Y: got %0d want 23", obs_ys); end
      end
    end
    nvec++; if (idx != 2) begin nerr++; $display("FAIL bp_capacity: got %0d accepts want 2", idx); end
    nvec++; if (obs_ready !== 1'b0) begin nerr++; $display("FAIL bp_in_ready: got %b want 0", obs_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = idx < 4;
      X = 16'(idx + 1);
      tick();
      if (obs_acc) idx++;
      if (obs_pop) begin
        nvec++;
        if (n > 3) begin nerr++; $display("FAIL bp_extra: got Y=%0d want none", obs_ys); end
        else if (obs_ys !== 16'(tbl[n])) begin nerr++; $display("FAIL bp_out%0d: got %0d want %0d", n, obs_ys, tbl[n]); end
        n++;
      end
    end
    in_valid = 1'b0;
    nvec++; if (n != 4 || idx != 4) begin nerr++; $display("FAIL bp_count: got %0d out/%0d in want 4/4", n, idx); end
  endtask

  task automatic test_saturate();
    int n = 0;
    exp_q.delete();
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = c < 2;
      X = (c == 0) ? 16'sd20000 : -16'sd20000;
      tick();
      if (obs_pop && n < 2) begin
        nvec++;
        if (obs_ys !== (n == 0 ? 16'sd32767 : -16'sd32768) || obs_os !== 1'b1) begin
          nerr++; $display("FAIL sat_out%0d: got Y=%0d ovf=%b want Y=%0d ovf=1", n, obs_ys, obs_os, n == 0 ? 32767 : -32768);
        end
        nvec++;
        if (obs_yw !== (n == 0 ? -16'sd11055 : 16'sd11089) || obs_ow !== 1'b1) begin
          nerr++; $display("FAIL wrap_out%0d: got Y=%0d ovf=%b want Y=%0d ovf=1", n, obs_yw, obs_ow, n == 0 ? -11055 : 11089);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    nvec++; if (n != 2) begin nerr++; $display("FAIL sat_count: got %0d want 2", n); end
    tick();
    nvec++; if (obs_sticky !== 1'b1) begin nerr++; $display("FAIL sticky_set: got %b want 1", obs_sticky); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    nvec++; if (obs_sticky !== 1'b0) begin nerr++; $display("FAIL sticky_clr: got %b want 0", obs_sticky); end
  endtask

  task automatic test_set_wins();
    exp_q.delete();
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    X = 16'sd20000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    nvec++; if (obs_sticky !== 1'b1) begin nerr++; $display("FAIL set_wins: sticky got %b want 1", obs_sticky); end
    tick();
    nvec++; if (obs_sticky !== 1'b0) begin nerr++; $display("FAIL clr_after_set: sticky got %b want 0", obs_sticky); end
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    exp_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    X = 16'sd5;
    tick();
    X = 16'sd6;
    tick();
    in_valid = 1'b0;
    nvec++; if (out_valid_s !== 1'b1) begin nerr++; $display("FAIL mid_prefill: out_valid got %b want 1", out_valid_s); end
    rst = 1'b1;
    #1;
    nvec++; if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin nerr++; $display("FAIL mid_async_drop: out_valid got %b/%b want 0", out_valid_s, out_valid_w); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nvec++; if (obs_valid !== 1'b0) begin nerr++; $display("FAIL mid_stale%0d: out_valid got %b want 0", c, obs_valid); end
    end
    X = 16'sd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      if (obs_pop) begin
        seen = 1'b1;
        nvec++; if (obs_ys !== 16'sd77) begin nerr++; $display("FAIL mid_after_Y: got %0d want 77", obs_ys); end
      end
    end
    if (!seen) begin nvec++; nerr++; $display("FAIL mid_after_timeout: got no output want Y=77"); end
  endtask

  task automatic test_random();
    int v, occ;
    bit hold_prev = 1'b0;
    logic signed [15:0] hy = '0;
    logic ho = 1'b0;
    exp_q.delete();
    ovf_clr = 1'b0;
    for (int c = 0; c < 420; c++) begin
      in_valid = c < 400 && $urandom_range(0, 3) != 0;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
      X = 16'(v);
      out_ready = c >= 400 || $urandom_range(0, 2) != 0;
      tick();
      occ = exp_q.size() - int'(obs_acc);
      nvec++;
      if (obs_ready !== ((occ < 2) || out_ready)) begin
        nerr++; $display("FAIL rand_in_ready: cycle %0d got %b want %b (occupancy %0d)", c, obs_ready, (occ < 2) || out_ready, occ);
      end
      if (hold_prev) begin
        nvec++;
        if (obs_ys !== hy || obs_os !== ho) begin nerr++; $display("FAIL rand_stable: cycle %0d got Y=%0d ovf=%b want Y=%0d ovf=%b", c, obs_ys, obs_os, hy, ho); end
      end
      hold_prev = obs_valid & !out_ready;
      hy = obs_ys;
      ho = obs_os;
      if (obs_pop) begin
        nvec++;
        if (exp_q.size() == 0) begin nerr++; $display("FAIL rand_extra: got Y=%0d want none", obs_ys); end
        else begin
          e = exp_q.pop_front();
          if (obs_ys !== e.ys || obs_yw !== e.yw || obs_os !== e.os || obs_ow !== e.ow) begin
            nerr++; $display("FAIL rand_data: cycle %0d got %0d/%0d ovf %b/%b want %0d/%0d ovf %b/%b", c, obs_ys, obs_yw, obs_os, obs_ow, e.ys, e.yw, e.os, e.ow);
          end
        end
      end
    end
    in_valid = 1'b0;
    nvec++; if (exp_q.size() != 0) begin nerr++; $display("FAIL rand_lost: %0d samples missing want 0", exp_q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_saturate();
    test_set_wins();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
